// File: rtl/otter_pkg.sv
// Shared OTTER core types: write-back select and load-size encodings.
package otter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_PC  = 2'd0,
    WB_CSR = 2'd1,
    WB_MEM = 2'd2,
    WB_ALU = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary signal bundle; slave is the stage, master is the surrounding pipeline.
// Forwarding outputs exist only when OTTER_WB_FWD_EN is defined.
interface mem_wb_stage_if;

  logic        STALL;
  logic        FLUSH;
  logic        MEM_VALID;
  logic [31:0] ALU_OUT_M;
  logic [31:0] PC_PLUS4_M;
  logic [31:0] CSR_RD_M;
  logic [4:0]  RD_ADDR_M;
  logic [1:0]  RF_WR_SEL_M;
  logic        REG_WRITE_M;
  logic [1:0]  MEM_SIZE_M;
  logic        MEM_UNS_M;
  logic [31:0] MEM_DOUT_RAW;

  logic [31:0] ALU_OUT_W;
  logic [31:0] CSR_RD_W;
  logic [31:0] PC_OUT_W;
  logic [31:0] MEM_DOUT_2_W;
  logic [1:0]  RF_WR_SEL_W;
  logic [4:0]  RD_ADDR_W;
  logic        REG_WRITE_W;
  logic        WB_VALID;
  logic [63:0] INSTRET;
`ifdef OTTER_WB_FWD_EN
  logic        FWD_VALID;
  logic [4:0]  FWD_RD;
  logic [31:0] FWD_DATA;
`endif

  modport slave (
    input  STALL, FLUSH, MEM_VALID, ALU_OUT_M, PC_PLUS4_M, CSR_RD_M,
           RD_ADDR_M, RF_WR_SEL_M, REG_WRITE_M, MEM_SIZE_M, MEM_UNS_M,
           MEM_DOUT_RAW,
    output ALU_OUT_W, CSR_RD_W, PC_OUT_W, MEM_DOUT_2_W, RF_WR_SEL_W,
           RD_ADDR_W, REG_WRITE_W, WB_VALID, INSTRET
`ifdef OTTER_WB_FWD_EN
    , output FWD_VALID, FWD_RD, FWD_DATA
`endif
  );

  modport master (
    output STALL, FLUSH, MEM_VALID, ALU_OUT_M, PC_PLUS4_M, CSR_RD_M,
           RD_ADDR_M, RF_WR_SEL_M, REG_WRITE_M, MEM_SIZE_M, MEM_UNS_M,
           MEM_DOUT_RAW,
    input  ALU_OUT_W, CSR_RD_W, PC_OUT_W, MEM_DOUT_2_W, RF_WR_SEL_W,
           RD_ADDR_W, REG_WRITE_W, WB_VALID, INSTRET
`ifdef OTTER_WB_FWD_EN
    , input FWD_VALID, FWD_RD, FWD_DATA
`endif
  );

endinterface

// File: rtl/load_align.sv
// Combinational load-data alignment: picks byte/half lane by address and extends to XLEN.
module load_align
  import otter_pkg::*;
(
  input  logic [XLEN-1:0] src,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = src[7:0];
      2'd1:    byte_v = src[15:8];
      2'd2:    byte_v = src[23:16];
      default: byte_v = src[31:24];
    endcase
    // Half-word lane chosen by addr bit 1 only; misaligned bit 0 is ignored.
    half_v = addr_lo[1] ? src[31:16] : src[15:0];

    data = src;
    if (size == SZ_BYTE) begin
      data = {{24{~uns & byte_v[7]}}, byte_v};
    end else if (size == SZ_HALF) begin
      data = {{16{~uns & half_v[15]}}, half_v};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, stall-safe load hold and INSTRET counter.
// Define OTTER_WB_FWD_EN to add the FWD_VALID/FWD_RD/FWD_DATA forwarding outputs.
module mem_wb_stage
  import otter_pkg::*;
(
  input  logic           CLK,
  input  logic           RST_N,
  mem_wb_stage_if.slave  bus
);

  logic [31:0] alu_p1;
  logic [31:0] pc_p1;
  logic [31:0] csr_p1;
  logic [4:0]  rd_p1;
  logic [1:0]  sel_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;
  logic [1:0]  addr_lo_p1;
  logic        rw_p1;
  logic        vld_p1;
  logic [31:0] hold_q;
  logic        held_q;
  logic [63:0] instret_q;
  logic [31:0] load_src;
  logic [31:0] load_data;
  logic        advance;
  logic        bubble;

  assign advance = ~bus.STALL;
  assign bubble  = bus.FLUSH | ~bus.MEM_VALID;

  // MEM -> WB boundary
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_p1     <= '0;
      pc_p1      <= '0;
      csr_p1     <= '0;
      rd_p1      <= '0;
      sel_p1     <= '0;
      size_p1    <= '0;
      uns_p1     <= 1'b0;
      addr_lo_p1 <= '0;
      rw_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      hold_q     <= '0;
      held_q     <= 1'b0;
      instret_q  <= '0;
    end else if (advance) begin
      alu_p1     <= bus.ALU_OUT_M;
      pc_p1      <= bus.PC_PLUS4_M;
      csr_p1     <= bus.CSR_RD_M;
      rd_p1      <= bus.RD_ADDR_M;
      sel_p1     <= bus.RF_WR_SEL_M;
      size_p1    <= bus.MEM_SIZE_M;
      uns_p1     <= bus.MEM_UNS_M;
      addr_lo_p1 <= bus.ALU_OUT_M[1:0];
      rw_p1      <= bus.REG_WRITE_M & ~bubble;
      vld_p1     <= ~bubble;
      held_q     <= 1'b0;
      if (vld_p1) begin
        instret_q <= instret_q + 64'd1;
      end
    end else if (!held_q) begin
      // Memory only drives the read word for one cycle; keep it for the rest of the stall.
      hold_q <= bus.MEM_DOUT_RAW;
      held_q <= 1'b1;
    end
  end

  assign load_src = held_q ? hold_q : bus.MEM_DOUT_RAW;

  load_align u_load_align (
    .src     (load_src),
    .addr_lo (addr_lo_p1),
    .size    (size_p1),
    .uns     (uns_p1),
    .data    (load_data)
  );

  assign bus.ALU_OUT_W    = alu_p1;
  assign bus.CSR_RD_W     = csr_p1;
  assign bus.PC_OUT_W     = pc_p1;
  assign bus.MEM_DOUT_2_W = load_data;
  assign bus.RF_WR_SEL_W  = sel_p1;
  assign bus.RD_ADDR_W    = rd_p1;
  assign bus.REG_WRITE_W  = vld_p1 & rw_p1 & (rd_p1 != 5'd0);
  assign bus.WB_VALID     = vld_p1;
  assign bus.INSTRET      = instret_q;

`ifdef OTTER_WB_FWD_EN
  logic [31:0] fwd_data;

  always_comb begin
    fwd_data = alu_p1;
    case (wb_sel_t'(sel_p1))
      WB_PC:   fwd_data = pc_p1;
      WB_CSR:  fwd_data = csr_p1;
      WB_MEM:  fwd_data = load_data;
      default: fwd_data = alu_p1;
    endcase
  end

  assign bus.FWD_VALID = bus.REG_WRITE_W;
  assign bus.FWD_RD    = rd_p1;
  assign bus.FWD_DATA  = fwd_data;
`endif

endmodule
